// File: rtl/ro_sampler_if.sv
// ro_sampler_if: word output channel of the ring-oscillator sampler.
//   data  : random word, meaningful only while valid=1
//   valid : producer has a word available
//   rdy   : consumer can take the word
//
// Handshake: a word transfers on a rising clk edge where valid && rdy.
// Once valid rises, the producer holds valid and data stable until that
// transfer. The producer never waits on rdy before raising valid. The
// consumer may drive rdy freely.
//
// Modports:
//   master : the sampler (drives data/valid, observes rdy)
//   slave  : the consumer (observes data/valid, drives rdy)
interface ro_sampler_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             rdy;

  modport master (output data, output valid, input rdy);
  modport slave  (input data, input valid, output rdy);
endinterface

// File: rtl/ro_sampler.sv
// ro_sampler: consumer end of the ring-oscillator entropy path.
// Enables the oscillator, synchronises its output, takes one raw sample
// every DIV cycles, debiases with a von Neumann corrector and packs the
// corrected bits into WIDTH-bit words presented on a valid/ready channel.
// A repetition-count health test on the raw samples latches a sticky
// fault when the oscillator looks stuck.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en          : request continuous generation
//   ro_in       : oscillator output, asynchronous to clk
//   ro_activate : oscillator enable
//   fault       : sticky health-test failure (cleared only by rst)
//   state_dbg   : current FSM state (IDLE=0, WARMUP=1, COLLECT=2, HOLD=3)
//   out         : word channel (data/valid/rdy)
//
// WIDTH must be >= 2, DIV >= 2, WARMUP >= 1.
module ro_sampler #(
  parameter int WIDTH    = 8,
  parameter int DIV      = 4,
  parameter int WARMUP   = 16,
  parameter int RC_LIMIT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ro_in,
  output logic        ro_activate,
  output logic        fault,
  output logic [1:0]  state_dbg,
  ro_sampler_if.master out
);

  localparam int DW = $clog2(DIV);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(RC_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP_S = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t state, state_next;

  logic          s1, s2;
  logic [WW-1:0] warm_cnt;
  logic [DW-1:0] div_cnt;
  logic          half;
  logic          first_bit;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] rep;
  logic          prev;

  logic          strobe;
  logic [RW-1:0] rep_next;
  logic          fault_hit;
  logic          emit;
  logic          word_done;
  logic [WIDTH-1:0] word_full;

  // Two-flop synchroniser; runs in every state so s2 is settled by COLLECT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ro_in;
      s2 <= s1;
    end
  end

  always_comb begin
    strobe    = (state == COLLECT) && en && (div_cnt == DW'(DIV - 1));
    // rep==0 marks the first sample since IDLE, which starts a new run.
    if (rep == '0 || s2 != prev) rep_next = RW'(1);
    else                         rep_next = rep + RW'(1);
    fault_hit = strobe && (rep_next == RW'(RC_LIMIT));
    emit      = strobe && half && (first_bit != s2);
    word_done = emit && (bit_cnt == BW'(WIDTH - 1)) && !fault_hit;
    word_full = {sreg[WIDTH-2:0], first_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (en && !fault) state_next = WARMUP_S;
      WARMUP_S: begin
        if (!en)                               state_next = IDLE;
        else if (warm_cnt == WW'(WARMUP - 1))  state_next = COLLECT;
      end
      COLLECT: begin
        if (!en)            state_next = IDLE;
        else if (fault_hit) state_next = IDLE;
        else if (word_done) state_next = HOLD;
      end
      HOLD:     if (out.rdy) state_next = en ? COLLECT : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt  <= '0;
      div_cnt   <= '0;
      half      <= 1'b0;
      first_bit <= 1'b0;
      sreg      <= '0;
      bit_cnt   <= '0;
      rep       <= '0;
      prev      <= 1'b0;
      fault     <= 1'b0;
      out.data  <= '0;
      out.valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Everything except fault and the last word restarts from scratch.
          warm_cnt  <= '0;
          div_cnt   <= '0;
          half      <= 1'b0;
          first_bit <= 1'b0;
          sreg      <= '0;
          bit_cnt   <= '0;
          rep       <= '0;
          prev      <= 1'b0;
        end
        WARMUP_S: begin
          if (en && warm_cnt != WW'(WARMUP - 1)) warm_cnt <= warm_cnt + WW'(1);
        end
        COLLECT: begin
          if (en) begin
            if (strobe) begin
              div_cnt <= '0;
              rep     <= rep_next;
              prev    <= s2;
              if (!half) begin
                first_bit <= s2;
                half      <= 1'b1;
              end else begin
                half <= 1'b0;
                if (emit) begin
                  sreg    <= word_full;
                  bit_cnt <= bit_cnt + BW'(1);
                end
              end
              if (fault_hit) begin
                fault <= 1'b1;
              end else if (word_done) begin
                out.data  <= word_full;
                out.valid <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
        end
        HOLD: begin
          // Divider and corrector stay frozen; a fresh word starts on accept.
          if (out.rdy) begin
            out.valid <= 1'b0;
            div_cnt   <= '0;
            half      <= 1'b0;
            sreg      <= '0;
            bit_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ro_activate = (state != IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_ro_sampler.sv
// tb_ro_sampler: directed bench for ro_sampler. Stimulus pushes expected
// words into exp_q; a monitor pops and compares on every accepted word.
module tb_ro_sampler;
  localparam int WIDTH    = 8;
  localparam int DIV      = 4;
  localparam int WARMUP   = 16;
  localparam int RC_LIMIT = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WARMUP  = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ro_in;
  logic       ro_activate;
  logic       fault;
  logic [1:0] state_dbg;

  ro_sampler_if #(.WIDTH(WIDTH)) bus ();

  ro_sampler #(
    .WIDTH(WIDTH), .DIV(DIV), .WARMUP(WARMUP), .RC_LIMIT(RC_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ro_in(ro_in),
    .ro_activate(ro_activate), .fault(fault), .state_dbg(state_dbg),
    .out(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.valid && bus.rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h with no word expected at %0t", bus.data, $time);
      end else begin
        chk("word", 32'(bus.data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at the edge where COLLECT is entered; presents one raw bit per
  // sample period, changing ro_in on the falling edge after each strobe.
  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ro_in = bits[n-1-k];
      repeat (DIV) @(posedge clk);
    end
  endtask

  // Raise en just after a rising edge and run until COLLECT is entered.
  task automatic start_and_warm(input string tag);
    #1 en = 1'b1;
    @(posedge clk);
    #1 chk({tag, "_act_after_en"}, 32'(ro_activate), 32'd1);
    chk({tag, "_warmup_state"}, 32'(state_dbg), 32'(ST_WARMUP));
    repeat (WARMUP) @(posedge clk);
  endtask

  // Accept the held word; keep_en selects COLLECT or IDLE afterwards.
  task automatic accept(input logic keep_en);
    #1;
    bus.rdy = 1'b1;
    en      = keep_en;
    @(posedge clk);
    #1 bus.rdy = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    rst = 1'b1; en = 1'b0; ro_in = 1'b0; bus.rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_act", 32'(ro_activate), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk);

    // Basic word: pairs 10,01 x4 -> 1010_1010
    exp_q.push_back(8'hAA);
    start_and_warm("basic");
    send_bits(64'b1001_1001_1001_1001, 16);
    #1 chk("basic_valid", 32'(bus.valid), 32'd1);
    chk("basic_hold", 32'(state_dbg), 32'(ST_HOLD));
    accept(1'b0);
    chk("basic_valid_drop", 32'(bus.valid), 32'd0);
    chk("basic_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Discard: eight 10 pairs with 00/11 between them -> 0xFF
    exp_q.push_back(8'hFF);
    start_and_warm("disc");
    send_bits(64'b10_00_10_11_10_00_10_11_10_00_10_11_10_00, 28);
    #1 chk("disc_no_valid_7pairs", 32'(bus.valid), 32'd0);
    send_bits(64'b10, 2);
    #1 chk("disc_valid", 32'(bus.valid), 32'd1);
    chk("disc_no_fault", 32'(fault), 32'd0);
    accept(1'b0);

    // Backpressure: word 0xC3, held 100 cycles, then back-to-back 0x3C
    exp_q.push_back(8'hC3);
    start_and_warm("bp");
    send_bits(64'b10_10_01_01_01_01_10_10, 16);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 if (bus.valid !== 1'b1 || bus.data !== 8'hC3 || state_dbg !== ST_HOLD) bad++;
    end
    chk("bp_hold_stable_bad_cycles", 32'(bad), 32'd0);
    exp_q.push_back(8'h3C);
    accept(1'b1);
    chk("bp_valid_drop", 32'(bus.valid), 32'd0);
    chk("bp_no_warmup", 32'(state_dbg), 32'(ST_COLLECT));
    send_bits(64'b01_01_10_10_10_10_01_01, 16);
    #1 chk("bp_second_valid", 32'(bus.valid), 32'd1);
    accept(1'b0);

    // Abort mid-word, then re-enable with 01 x8 -> 0x00
    start_and_warm("abort");
    send_bits(64'b10_01_10, 6);
    #1 en = 1'b0;
    @(posedge clk);
    #1 chk("abort_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("abort_act", 32'(ro_activate), 32'd0);
    exp_q.push_back(8'h00);
    start_and_warm("reen");
    send_bits(64'b01_01_01_01_01_01_01_01, 16);
    #1 chk("reen_valid", 32'(bus.valid), 32'd1);
    accept(1'b0);

    // Stuck input: 32nd identical sample trips the fault
    ro_in = 1'b1;
    repeat (4) @(posedge clk);
    start_and_warm("stuck");
    bad = 0;
    for (int i = 0; i < (RC_LIMIT - 1) * DIV; i++) begin
      @(posedge clk);
      #1 if (bus.valid !== 1'b0) bad++;
    end
    chk("stuck_fault_early", 32'(fault), 32'd0);
    repeat (DIV) @(posedge clk);
    #1 chk("stuck_fault", 32'(fault), 32'd1);
    chk("stuck_act", 32'(ro_activate), 32'd0);
    chk("stuck_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("stuck_valid_cycles", 32'(bad), 32'd0);
    en = 1'b0;
    @(posedge clk);
    #1 en = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("stuck_en_ignored_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("stuck_en_ignored_act", 32'(ro_activate), 32'd0);
    chk("stuck_sticky", 32'(fault), 32'd1);
    en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("fault_cleared", 32'(fault), 32'd0);
    ro_in = 1'b0;
    @(posedge clk);

    // Async reset while holding a word
    start_and_warm("arst");
    send_bits(64'b1001_1001_1001_1001, 16);
    #1 chk("arst_valid_before", 32'(bus.valid), 32'd1);
    chk("arst_data_before", 32'(bus.data), 32'hAA);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_data", 32'(bus.data), 32'd0);
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_act", 32'(ro_activate), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    #1 chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
